// File: rtl/immediate_encoder.sv
// immediate_encoder: two-stage valid/ready packer. It range-checks a 16-bit
// immediate for the instruction class of a template and then inserts the
// immediate into that template's immediate field. A saturating counter tracks
// how many instructions had an errored immediate.
module immediate_encoder #(
  parameter int CNT_W    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear
);

  typedef enum logic [2:0] {
    K_NONE,
    K_LDST,
    K_ADDI,
    K_BRANCH,
    K_CMP,
    K_UCMP,
    K_SHIFT
  } kind_t;

  kind_t             w_kind;
  logic              w_err;
  logic              w_sx5, w_sx6, w_sx11;
  logic              w_en1, w_en2, w_keep, w_cnt_inc;
  logic [15:0]       w_field;

  logic              r_v1;
  kind_t             r_kind1;
  logic [15:0]       r_instr1;
  logic [11:0]       r_imm1;
  logic              r_err1;

  logic              r_v2;
  logic [15:0]       r_instr2;
  logic              r_err2;
  logic [CNT_W-1:0]  r_cnt;

  // A signed field fits when every bit from its sign bit upward agrees.
  assign w_sx5  = (&in_imm[15:5])  | ~(|in_imm[15:5]);
  assign w_sx6  = (&in_imm[15:6])  | ~(|in_imm[15:6]);
  assign w_sx11 = (&in_imm[15:11]) | ~(|in_imm[15:11]);

  assign w_en2    = ~r_v2 | out_ready;
  assign w_en1    = ~r_v1 | w_en2;
  assign in_ready = w_en1;

  // Errored items are discarded on their way into stage 2 when DROP_ERR is set.
  assign w_keep    = r_v1 & ~(DROP_ERR & r_err1);
  assign w_cnt_inc = DROP_ERR ? (r_v1 & w_en2 & r_err1)
                              : (r_v2 & out_ready & r_err2);

  // Classify the incoming template by class and opcode bits.
  always_comb begin
    w_kind = K_NONE;
    case (in_instr[15:14])
      2'b00: w_kind = in_instr[13] ? K_ADDI : K_LDST;
      2'b10: begin
        case (in_instr[13:11])
          3'b101:  w_kind = K_CMP;
          3'b110:  w_kind = K_UCMP;
          3'b111:  w_kind = K_NONE;
          default: w_kind = K_BRANCH;
        endcase
      end
      2'b11:   w_kind = K_SHIFT;
      default: w_kind = K_NONE;
    endcase
  end

  // Range and alignment check of the immediate for the classified kind.
  always_comb begin
    w_err = 1'b0;
    case (w_kind)
      K_LDST:   w_err = in_imm[0] | ~w_sx6;
      K_ADDI:   w_err = ~w_sx5;
      K_BRANCH: w_err = in_imm[0] | ~w_sx11;
      K_CMP:    w_err = ~w_sx6;
      K_UCMP:   w_err = |in_imm[15:7];
      K_SHIFT:  w_err = |in_imm[15:4];
      default:  w_err = 1'b0;
    endcase
  end

  // Insert the (possibly truncated) immediate into the stage-1 template.
  always_comb begin
    w_field = r_instr1;
    case (r_kind1)
      K_LDST:       w_field = {r_instr1[15:6], r_imm1[6:1]};
      K_ADDI:       w_field = {r_instr1[15:6], r_imm1[5:0]};
      K_BRANCH:     w_field = {r_instr1[15:11], r_imm1[11:1]};
      K_CMP,
      K_UCMP:       w_field = {r_instr1[15:7], r_imm1[6:0]};
      K_SHIFT:      w_field = {r_instr1[15:5], r_imm1[3:0], r_instr1[0]};
      default:      w_field = r_instr1;
    endcase
  end

  // Stage 1: capture the template, its kind and the range-check result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_kind1  <= K_NONE;
      r_instr1 <= '0;
      r_imm1   <= '0;
      r_err1   <= 1'b0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_kind1  <= w_kind;
        r_instr1 <= in_instr;
        r_imm1   <= in_imm[11:0];
        r_err1   <= w_err;
      end
    end
  end

  // Stage 2: hold the encoded instruction and its error flag for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_instr2 <= '0;
      r_err2   <= 1'b0;
    end else if (w_en2) begin
      r_v2 <= w_keep;
      if (w_keep) begin
        r_instr2 <= w_field;
        r_err2   <= r_err1;
      end
    end
  end

  // Saturating error counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (err_clear) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && !(&r_cnt)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_v2;
  assign out_instr = r_instr2;
  assign out_err   = r_err2;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_immediate_encoder.sv
// Bench for immediate_encoder: one instance with errored items emitted and one
// with them dropped, both checked against an arithmetic field model.
module tb_immediate_encoder;

  typedef struct {
    logic [15:0] t;
    logic [15:0] imm;
    bit          has_k;
    logic [15:0] k_instr;
    bit          k_err;
  } stim_t;

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field description per instruction class, straight from the encoding table.
  function automatic void finfo(input logic [15:0] t, output bit has, output int pos,
                                output int w, output int sh, output bit sgn,
                                output int lo, output int hi);
    has = 1; pos = 0; w = 0; sh = 0; sgn = 1; lo = 0; hi = 0;
    case (t[15:14])
      2'd0: if (t[13] == 1'b0) begin w = 6; sh = 1; lo = -64; hi = 62; end
            else begin w = 6; lo = -32; hi = 31; end
      2'd2: begin
        if (t[13:11] <= 3'd4) begin w = 11; sh = 1; lo = -2048; hi = 2046; end
        else if (t[13:11] == 3'd5) begin w = 7; lo = -64; hi = 63; end
        else if (t[13:11] == 3'd6) begin w = 7; sgn = 0; lo = 0; hi = 127; end
        else has = 0;
      end
      2'd3: begin w = 4; pos = 1; sgn = 0; lo = 0; hi = 15; end
      default: has = 0;
    endcase
  endfunction

  function automatic int ival(input logic [15:0] imm, input bit sgn);
    return sgn ? int'($signed(imm)) : int'(imm);
  endfunction

  function automatic void ref_enc(input logic [15:0] t, input logic [15:0] imm,
                                  output logic [15:0] o, output bit e);
    bit has, sgn; int pos, w, sh, lo, hi, v, mask, f;
    finfo(t, has, pos, w, sh, sgn, lo, hi);
    o = t; e = 0;
    if (has) begin
      v    = ival(imm, sgn);
      e    = (v < lo) || (v > hi) || (sh == 1 && (v % 2) != 0);
      mask = (1 << w) - 1;
      f    = (v >>> sh) & mask;
      o    = 16'((int'(t) & ~(mask << pos)) | (f << pos));
    end
  endfunction

  function automatic int decode(input logic [15:0] o, input int pos, input int w,
                                input int sh, input bit sgn);
    int f;
    f = (int'(o) >> pos) & ((1 << w) - 1);
    if (sgn && f >= (1 << (w - 1))) f -= (1 << w);
    return f * (1 << sh);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_h
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_err, err_clear;
    logic [15:0] in_instr, in_imm, out_instr;
    logic [7:0]  err_count;
    stim_t       stim_q[$];
    stim_t       exp_q[$];
    int unsigned mcnt = 0;
    int unsigned acc = 0;
    int unsigned nout = 0;

    immediate_encoder #(.CNT_W(8), .DROP_ERR(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
      .err_count(err_count), .err_clear(err_clear));

    initial begin : drv
      in_valid = 1'b0; in_instr = '0; in_imm = '0;
      forever begin
        @(posedge clk); #1;
        if (stim_q.size() > 0) begin
          in_valid = 1'b1; in_instr = stim_q[0].t; in_imm = stim_q[0].imm;
        end else begin
          in_valid = 1'b0;
        end
      end
    end

    initial begin : mon
      stim_t s;
      logic [15:0] o;
      bit e, has, sgn;
      int pos, w, sh, lo, hi;
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (g == 0) chk("err_count0", err_count, mcnt);
          if (out_valid && out_ready) begin
            nout++;
            if (exp_q.size() == 0) begin
              chk("unexpected_out", 1, 0);
            end else begin
              s = exp_q.pop_front();
              ref_enc(s.t, s.imm, o, e);
              chk("out_instr", out_instr, o);
              chk("out_err", out_err, e);
              if (s.has_k) begin
                chk("known_instr", out_instr, s.k_instr);
                chk("known_err", out_err, s.k_err);
              end
              finfo(s.t, has, pos, w, sh, sgn, lo, hi);
              if (has && !e) chk("roundtrip", decode(out_instr, pos, w, sh, sgn), ival(s.imm, sgn));
              if (g == 0 && e && !err_clear && mcnt < 255) mcnt++;
            end
          end
          if (g == 0 && err_clear) mcnt = 0;
          if (in_valid && in_ready && stim_q.size() > 0) begin
            s = stim_q.pop_front();
            acc++;
            ref_enc(s.t, s.imm, o, e);
            if (g == 1 && e) begin
              if (mcnt < 255) mcnt++;
            end else begin
              exp_q.push_back(s);
            end
          end
        end
      end
    end
  end

  task automatic add(input int g, input logic [15:0] t, input logic [15:0] imm,
                     input bit has_k, input logic [15:0] k_instr, input bit k_err);
    stim_t s;
    s.t = t; s.imm = imm; s.has_k = has_k; s.k_instr = k_instr; s.k_err = k_err;
    if (g == 0) g_h[0].stim_q.push_back(s);
    else        g_h[1].stim_q.push_back(s);
  endtask

  task automatic addk(input logic [15:0] t, input logic [15:0] imm,
                      input logic [15:0] k, input bit ke);
    add(0, t, imm, 1, k, ke);
  endtask

  task automatic wait_drain(input int g);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (g == 0) done = (g_h[0].stim_q.size() == 0) && (g_h[0].exp_q.size() == 0);
      else        done = (g_h[1].stim_q.size() == 0) && (g_h[1].exp_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rnd_imm();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'(int'($urandom_range(0, 140)) - 70);
      2:       return 16'($urandom_range(0, 20));
      default: return 16'(int'($urandom_range(0, 4200)) - 2100);
    endcase
  endfunction

  initial begin : main
    int unsigned a0, n0;
    bit done;
    g_h[0].rst_n = 1'b0; g_h[1].rst_n = 1'b0;
    g_h[0].out_ready = 1'b1; g_h[1].out_ready = 1'b1;
    g_h[0].err_clear = 1'b0; g_h[1].err_clear = 1'b0;
    #3;
    chk("rst_valid", g_h[0].out_valid, 0);
    chk("rst_instr", g_h[0].out_instr, 0);
    chk("rst_err", g_h[0].out_err, 0);
    chk("rst_count", g_h[0].err_count, 0);
    chk("rst_ready", g_h[0].in_ready, 1);
    chk("rst_valid1", g_h[1].out_valid, 0);
    @(posedge clk); #2;
    g_h[0].rst_n = 1'b1; g_h[1].rst_n = 1'b1;
    repeat (2) @(posedge clk); #2;
    chk("ready_after_rst", g_h[0].in_ready, 1);

    // Latency: accept edge N, out_valid rises after edge N+1.
    a0 = g_h[0].acc;
    addk(16'h0000, 16'hFFFC, 16'h003E, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      done = (g_h[0].acc != a0);
    end
    if (!done) chk("lat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    chk("lat_edgeN_valid", g_h[0].out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edgeN1_valid", g_h[0].out_valid, 1);
    chk("lat_instr", g_h[0].out_instr, 16'h003E);
    wait_drain(0);

    // Directed field encodings and range boundaries.
    addk(16'h8000, 16'd2046, 16'h83FF, 0);
    addk(16'h8000, 16'd2047, 16'h83FF, 1);
    addk(16'h8000, 16'hF800, 16'h8400, 0);
    addk(16'hA000, 16'd2,    16'hA001, 0);
    addk(16'hB000, 16'd127,  16'hB07F, 0);
    addk(16'hB000, 16'hFFFF, 16'hB07F, 1);
    addk(16'hA800, 16'hFFFF, 16'hA87F, 0);
    addk(16'hA800, 16'hFFC0, 16'hA840, 0);
    addk(16'hA800, 16'd64,   16'hA840, 1);
    addk(16'hC001, 16'd9,    16'hC013, 0);
    addk(16'hC001, 16'd16,   16'hC001, 1);
    addk(16'h4123, 16'hFFFF, 16'h4123, 0);
    addk(16'hB8AB, 16'h1234, 16'hB8AB, 0);
    addk(16'h0000, 16'd62,   16'h001F, 0);
    addk(16'h0000, 16'hFFC0, 16'h0020, 0);
    addk(16'h0000, 16'd64,   16'h0020, 1);
    addk(16'h0000, 16'd3,    16'h0001, 1);
    addk(16'h2000, 16'hFFE0, 16'h2020, 0);
    addk(16'h2000, 16'd31,   16'h201F, 0);
    addk(16'h2000, 16'd32,   16'h2020, 1);
    wait_drain(0);
    chk("directed_err_count", g_h[0].err_count, 7);

    // Backpressure: two accepted while the output stalls, then in_ready drops.
    g_h[0].out_ready = 1'b0;
    a0 = g_h[0].acc; n0 = g_h[0].nout;
    for (int i = 1; i <= 4; i++) addk(16'h2000, 16'(i), 16'(16'h2000 + i), 0);
    repeat (5) @(negedge clk);
    #1;
    chk("bp_accepted", g_h[0].acc - a0, 2);
    chk("bp_in_ready", g_h[0].in_ready, 0);
    chk("bp_hold_valid", g_h[0].out_valid, 1);
    chk("bp_hold_instr", g_h[0].out_instr, 16'h2001);
    @(posedge clk); #2;
    g_h[0].out_ready = 1'b1;
    wait_drain(0);
    chk("bp_all_out", g_h[0].nout - n0, 4);

    // Random templates and immediates with random stalls and clears.
    for (int i = 0; i < 300; i++) add(0, 16'($urandom), rnd_imm(), 0, '0, 0);
    done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk); #2;
      g_h[0].out_ready = ($urandom_range(0, 3) != 0);
      g_h[0].err_clear = ($urandom_range(0, 40) == 0);
      done = (g_h[0].stim_q.size() == 0) && (g_h[0].exp_q.size() == 0);
    end
    g_h[0].out_ready = 1'b1; g_h[0].err_clear = 1'b0;
    wait_drain(0);

    // Dropping instance: errored middle item is discarded but counted.
    n0 = g_h[1].nout;
    add(1, 16'h2000, 16'd5,    1, 16'h2005, 0);
    add(1, 16'h2000, 16'd40,   0, '0, 0);
    add(1, 16'h2000, 16'hFFFF, 1, 16'h203F, 0);
    wait_drain(1);
    chk("drop_outputs", g_h[1].nout - n0, 2);
    chk("drop_count", g_h[1].err_count, 1);

    // Clear in the same cycle as a counted drop leaves zero.
    a0 = g_h[1].acc;
    add(1, 16'h2000, 16'd40, 0, '0, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      done = (g_h[1].acc != a0);
    end
    if (!done) chk("clr_accept_timeout", 0, 1);
    @(posedge clk); #1;
    g_h[1].err_clear = 1'b1;
    @(posedge clk); #1;
    g_h[1].err_clear = 1'b0;
    chk("clear_priority", g_h[1].err_count, 0);
    g_h[1].mcnt = 0;

    // Saturation at all-ones.
    for (int i = 0; i < 260; i++) add(1, 16'h2000, 16'd100, 0, '0, 0);
    wait_drain(1);
    chk("sat_count", g_h[1].err_count, 255);
    chk("sat_model", g_h[1].err_count, g_h[1].mcnt);
    g_h[1].err_clear = 1'b1;
    @(posedge clk); #2;
    g_h[1].err_clear = 1'b0;
    chk("sat_cleared", g_h[1].err_count, 0);
    g_h[1].mcnt = 0;

    // Reset mid-stream empties the pipeline at once.
    for (int i = 0; i < 10; i++) add(1, 16'h0000, 16'(2 * i), 0, '0, 0);
    repeat (4) @(posedge clk); #2;
    chk("pre_rst_valid", g_h[1].out_valid, 1);
    g_h[1].stim_q.delete();
    g_h[1].rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", g_h[1].out_valid, 0);
    chk("mid_rst_instr", g_h[1].out_instr, 0);
    chk("mid_rst_ready", g_h[1].in_ready, 1);
    repeat (2) @(posedge clk); #2;
    g_h[1].exp_q.delete();
    g_h[1].mcnt = 0;
    g_h[1].rst_n = 1'b1;
    n0 = g_h[1].nout;
    add(1, 16'hC000, 16'd15, 1, 16'hC01E, 0);
    add(1, 16'h8000, 16'hFFFE, 1, 16'h87FF, 0);
    wait_drain(1);
    chk("post_rst_outputs", g_h[1].nout - n0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
